// File: rtl/mag_search.sv
// Successive-approximation search that recovers a comparator's hidden `a` input.
// Optional probe-count output `steps` is enabled by MAG_SEARCH_STATS_EN.
module mag_search #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] probe,
  input  logic             cmp_equal,
  input  logic             cmp_a_great,
  input  logic             cmp_b_great,
  output logic             busy,
  output logic             done,
  output logic             err,
`ifdef MAG_SEARCH_STATS_EN
  output logic [4:0]       steps,
`endif
  output logic [WIDTH-1:0] result
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] TOP = BW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE,
    SEARCH
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    bit_q, bit_d, bm1;
  logic [WIDTH-1:0] probe_d, result_d, trial;
  logic             busy_d, done_d, err_d;
  logic [2:0]       flags;
  logic             onehot;
`ifdef MAG_SEARCH_STATS_EN
  logic [4:0]       cnt_q, cnt_d, steps_d;
`endif

  assign flags  = {cmp_equal, cmp_a_great, cmp_b_great};
  assign onehot = (flags == 3'b100) || (flags == 3'b010)
               || (flags == 3'b001);

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    probe_d  = probe;
    result_d = result;
    busy_d   = busy;
    done_d   = 1'b0;
    err_d    = 1'b0;
    trial    = probe;
    bm1      = bit_q - 1'b1;
`ifdef MAG_SEARCH_STATS_EN
    cnt_d    = cnt_q;
    steps_d  = steps;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEARCH;
          busy_d  = 1'b1;
          probe_d = MSB;
          bit_d   = TOP;
`ifdef MAG_SEARCH_STATS_EN
          cnt_d   = 5'd1;
`endif
        end
      end
      SEARCH: begin
        trial[bit_q] = cmp_a_great;
        if (!onehot) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          probe_d = '0;
          bit_d   = TOP;
        end else if (cmp_equal || bit_q == '0) begin
          // equal hits finish early; otherwise the last bit was just resolved
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          probe_d  = '0;
          bit_d    = TOP;
          result_d = cmp_equal ? probe : trial;
`ifdef MAG_SEARCH_STATS_EN
          steps_d  = cnt_q;
`endif
        end else begin
          trial[bm1] = 1'b1;
          probe_d    = trial;
          bit_d      = bm1;
`ifdef MAG_SEARCH_STATS_EN
          cnt_d      = cnt_q + 5'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= TOP;
      probe   <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef MAG_SEARCH_STATS_EN
      cnt_q   <= '0;
      steps   <= '0;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      probe   <= probe_d;
      result  <= result_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
`ifdef MAG_SEARCH_STATS_EN
      cnt_q   <= cnt_d;
      steps   <= steps_d;
`endif
    end
  end

endmodule
